prbs31_checker: RTL and testbench

Serial PRBS31 receiver/checker (x^31 + x^28 + 1) that sits directly downstream of the chip's PRBS31 generator. It consumes one bit per qualified clock and self-synchronises to the incoming sequence. Once locked, it counts bit errors and observed bits, and drops lock on excessive error density. Its outputs drive loopback/BER status pins.

---
 rtl/prbs31_checker.sv | 154 +++++++++++++++
 tb/tb_prbs31_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 (x^31 + x^28 + 1) serial checker.
// It seeds from the stream, verifies a run of predictions, then free-runs and counts errors and bits.
module prbs31_checker #(
  parameter int LOCK_CNT  = 64,
  parameter int LOSS_ERRS = 8,
  parameter int WINDOW    = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic [1:0]       state
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int ERR_W = $clog2(LOSS_ERRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [30:0]        sr_q, sr_d;
  logic [4:0]         seed_q, seed_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               err_pulse_q, err_pulse_d;

  logic pred;
  logic mismatch;
  logic win_end;
  logic err_inc;
  logic bit_inc;

  assign pred     = sr_q[27] ^ sr_q[30];
  // An all-zero register is the LFSR lock-up state, so it can never count as a match.
  assign mismatch = (bit_in != pred) || (sr_q == '0);
  assign win_end  = (win_cnt_q == WIN_W'(WINDOW - 1));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
    state_d     = state_q;
    sr_d        = sr_q;
    seed_d      = seed_q;
    run_d       = run_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    bit_inc     = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        SEED: begin
          sr_d = {sr_q[29:0], bit_in};
          if (seed_q == 5'd30) begin
            state_d = VERIFY;
            seed_d  = '0;
            run_d   = '0;
          end else begin
            seed_d = seed_q + 5'd1;
          end
        end
        VERIFY: begin
          sr_d = {sr_q[29:0], bit_in};
          if (mismatch) begin
            run_d = '0;
          end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
            state_d   = LOCKED;
            run_d     = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        LOCKED: begin
          // Free-run on the local prediction so a corrupted bit is counted once, not re-seeded.
          sr_d    = {sr_q[29:0], pred};
          bit_inc = 1'b1;
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (mismatch) win_err_d = win_err_q + 1'b1;
          end
          if (mismatch) begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (win_err_q == ERR_W'(LOSS_ERRS - 1)) begin
              state_d = SEED;
              seed_d  = '0;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      err_cnt_d = (err_inc && err_cnt_q != CNT_MAX) ? err_cnt_q + 1'b1 : err_cnt_q;
      bit_cnt_d = (bit_inc && bit_cnt_q != CNT_MAX) ? bit_cnt_q + 1'b1 : bit_cnt_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      sr_q        <= '0;
      seed_q      <= '0;
      run_q       <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      seed_q      <= seed_d;
      run_q       <= run_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock, single error, loss/relock, stuck-zero, gapped stream, saturation.
// A second instance with CNT_W=4, LOSS_ERRS=16 exercises counter saturation.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in, bit_valid, clr_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count, bit_count;
  logic [1:0]  state;

  logic        bit_in2, bit_valid2, clr2;
  logic        locked2, err_pulse2;
  logic [3:0]  err_count2, bit_count2;
  logic [1:0]  state2;

  logic [30:0] gen;
  logic        use2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count),
    .state(state)
  );

  prbs31_checker #(.LOCK_CNT(64), .LOSS_ERRS(16), .WINDOW(256), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in2), .bit_valid(bit_valid2), .clr_cnt(clr2),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .bit_count(bit_count2),
    .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One valid bit from the reference generator (serial output = MSB), optionally inverted.
  task automatic send(input logic flip, input logic clr);
    logic b;
    b   = gen[30];
    gen = {gen[29:0], gen[30] ^ gen[27]};
    if (use2) begin
      bit_in2 = b ^ flip; bit_valid2 = 1'b1; clr2 = clr;
    end else begin
      bit_in = b ^ flip; bit_valid = 1'b1; clr_cnt = clr;
    end
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_valid2 = 1'b0; clr_cnt = 1'b0; clr2 = 1'b0;
  endtask

  task automatic send_raw(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    gen = 31'd1;
    repeat (2) idle();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    int pulses, nvalid, gap_pulses;
    logic saw_lock, saw_verify;

    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
    bit_in2 = 1'b0; bit_valid2 = 1'b0; clr2 = 1'b0; use2 = 1'b0; gen = 31'd1;
    repeat (2) idle();
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_bit_count", bit_count, 0);
    rst_n = 1'b1;
    idle();

    // Lock on a clean stream: bit 94 still VERIFY, bit 95 locks.
    repeat (94) send(1'b0, 1'b0);
    check("pre_lock_locked", locked, 0);
    check("pre_lock_state", state, 1);
    send(1'b0, 1'b0);
    check("lock_locked", locked, 1);
    check("lock_state", state, 2);
    check("lock_err_count", err_count, 0);
    repeat (1000) send(1'b0, 1'b0);
    check("bits_1000", bit_count, 1000);
    check("clean_err_count", err_count, 0);

    // Single error: one pulse, locked stays, no propagation.
    send(1'b1, 1'b0);
    check("single_pulse", err_pulse, 1);
    check("single_err_count", err_count, 1);
    check("single_locked", locked, 1);
    send(1'b0, 1'b0);
    check("single_pulse_drop", err_pulse, 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      send(1'b0, 1'b0);
      pulses += int'(err_pulse);
    end
    check("single_no_propagation", pulses, 0);
    check("single_err_hold", err_count, 1);
    check("single_bit_count", bit_count, 1052);

    // Clear with no valid bit, then 8 errors in one window force loss of lock.
    clr_cnt = 1'b1; idle(); clr_cnt = 1'b0;
    check("clr_err_count", err_count, 0);
    check("clr_bit_count", bit_count, 0);
    check("clr_locked", locked, 1);
    for (int k = 0; k < 8; k++) begin
      repeat (9) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      if (k < 7) check("loss_still_locked", locked, 1);
    end
    check("loss_err_count", err_count, 8);
    check("loss_state", state, 0);
    check("loss_pulse", err_pulse, 1);
    check("loss_bit_count", bit_count, 80);
    repeat (94) send(1'b0, 1'b0);
    check("relock_pre", locked, 0);
    send(1'b0, 1'b0);
    check("relock", locked, 1);
    check("relock_bit_count", bit_count, 80);

    // Asynchronous reset mid-stream takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_err", err_count, 0);
    repeat (2) idle();
    rst_n = 1'b1;
    idle();

    // Stuck-at-zero input never locks.
    saw_lock = 1'b0; saw_verify = 1'b0;
    for (int i = 0; i < 500; i++) begin
      send_raw(1'b0);
      saw_lock   |= locked | (state == 2'd2) | (state == 2'd3);
      saw_verify |= (state == 2'd1);
    end
    check("zero_never_locked", saw_lock, 0);
    check("zero_reached_verify", saw_verify, 1);

    // Gapped clean stream: lock after 95 valid bits, only valid bits counted.
    do_reset();
    gap_pulses = 0;
    for (int i = 0; i < 95; i++) begin
      if ($urandom_range(0, 1) == 1) idle();
      send(1'b0, 1'b0);
      if (i == 93) check("gap_pre_lock", locked, 0);
    end
    check("gap_lock", locked, 1);
    nvalid = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        idle();
        gap_pulses += int'(err_pulse);
      end else begin
        send(1'b0, 1'b0);
        nvalid++;
      end
    end
    send(1'b1, 1'b0);
    nvalid++;
    idle();
    check("gap_pulse_after_idle", err_pulse, 0);
    check("gap_bit_count", bit_count, nvalid);
    check("gap_err_count", err_count, 1);
    check("gap_quiet_pulses", gap_pulses, 0);

    // Narrow counters saturate; clr_cnt wins over a coincident error.
    use2 = 1'b1;
    do_reset();
    repeat (95) send(1'b0, 1'b0);
    check("sat_lock", locked2, 1);
    for (int k = 0; k < 20; k++) begin
      repeat (31) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
    end
    check("sat_err_count", err_count2, 15);
    check("sat_bit_count", bit_count2, 15);
    check("sat_locked", locked2, 1);
    send(1'b1, 1'b1);
    check("clr_coincident_err", err_count2, 0);
    check("clr_coincident_bits", bit_count2, 0);
    check("clr_coincident_pulse", err_pulse2, 1);
    send(1'b0, 1'b0);
    check("post_clr_bits", bit_count2, 1);
    check("post_clr_err", err_count2, 0);
    check("post_clr_pulse", err_pulse2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
